// File: rtl/twpm_wb_router.sv
// Single-master Wishbone router: decodes the CPU address onto one of four slave
// windows, runs one transaction at a time and turns misses or hung slaves into bus errors.
module twpm_wb_router #(
    parameter logic [31:0] RAM_BASE_ADDRESS      = 32'h8000_0000,
    parameter int          RAM_ADDR_WIDTH        = 27,
    parameter logic [31:0] LITEDRAM_BASE_ADDRESS = 32'hF800_0000,
    parameter int          LITEDRAM_ADDR_WIDTH   = 14,
    parameter logic [31:0] TPM_REGS_BASE_ADDRESS = 32'hF000_0000,
    parameter int          TPM_REGS_ADDR_WIDTH   = 11,
    parameter logic [31:0] TPM_RAM_BASE_ADDRESS  = 32'hF000_0800,
    parameter int          TPM_RAM_ADDR_WIDTH    = 11,
    parameter int          TIMEOUT_CYCLES        = 1024,
    parameter logic [31:0] DEFAULT_READ_VALUE    = 32'hBADF_ABAC,
    parameter int          ERR_COUNT_WIDTH       = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    output logic [31:0]  wb_dat_o,
    input  logic         wb_we_i,
    input  logic [3:0]   wb_sel_i,
    input  logic         wb_stb_i,
    input  logic         wb_cyc_i,
    output logic         wb_ack_o,
    output logic         wb_err_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    output logic         s_we_o,
    output logic [3:0]   s_cyc_o,
    output logic [3:0]   s_stb_o,
    input  logic [127:0] s_dat_i,
    input  logic [3:0]   s_ack_i,
    input  logic [3:0]   s_err_i,
    output logic         busy_o,
    output logic         timeout_o,
    output logic [15:0]  err_count_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [31:0] BASE [4] = '{RAM_BASE_ADDRESS, LITEDRAM_BASE_ADDRESS,
                                          TPM_REGS_BASE_ADDRESS, TPM_RAM_BASE_ADDRESS};
    localparam int AW [4] = '{RAM_ADDR_WIDTH, LITEDRAM_ADDR_WIDTH,
                              TPM_REGS_ADDR_WIDTH, TPM_RAM_ADDR_WIDTH};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                     state, state_next;
    logic [1:0]                 sel_q, sel_next;
    logic [CW-1:0]              cnt, cnt_next;
    logic [ERR_COUNT_WIDTH-1:0] err_cnt;
    logic [3:0]                 hit;
    logic [1:0]                 hit_idx;
    logic                       hit_any;
    logic                       rsp_ack, rsp_err;
    logic [31:0]                rsp_data;
    logic                       done_set, done_err, done_tmo;
    logic [31:0]                done_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slave
            assign hit[gi]     = (wb_adr_i >> AW[gi]) == (BASE[gi] >> AW[gi]);
            assign s_stb_o[gi] = (state == BUSY) && (sel_q == 2'(gi));
            assign s_cyc_o[gi] = (state == BUSY) && (sel_q == 2'(gi));
        end
    endgenerate

    // Lowest index wins when windows overlap.
    always_comb begin
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) hit_idx = 2'(i);
        end
    end

    assign hit_any  = |hit;
    assign rsp_ack  = s_ack_i[sel_q];
    assign rsp_err  = s_err_i[sel_q];
    assign rsp_data = s_dat_i[{sel_q, 5'b0} +: 32];

    assign s_adr_o = wb_adr_i;
    assign s_dat_o = wb_dat_i;
    assign s_sel_o = wb_sel_i;
    assign s_we_o  = (state == BUSY) && wb_we_i;
    assign busy_o  = (state == BUSY);

    always_comb begin
        state_next = state;
        sel_next   = sel_q;
        cnt_next   = cnt;
        done_set   = 1'b0;
        done_err   = 1'b0;
        done_tmo   = 1'b0;
        done_data  = DEFAULT_READ_VALUE;
        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (hit_any) begin
                        sel_next   = hit_idx;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end else begin
                        done_set   = 1'b1;
                        done_err   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                // An abort beats a response arriving in the same cycle.
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                end else if (rsp_ack || rsp_err) begin
                    done_set   = 1'b1;
                    done_err   = rsp_err;
                    done_data  = rsp_data;
                    state_next = DONE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    done_set   = 1'b1;
                    done_err   = 1'b1;
                    done_tmo   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Master-side response registers load on the edge entering DONE, so they
    // are visible for exactly the one DONE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sel_q     <= 2'd0;
            cnt       <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= 32'h0;
            timeout_o <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            sel_q     <= sel_next;
            cnt       <= cnt_next;
            wb_ack_o  <= done_set && !done_err;
            wb_err_o  <= done_set && done_err;
            timeout_o <= done_tmo;
            if (done_set) wb_dat_o <= done_data;
            if (done_set && done_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_COUNT_WIDTH'(1);
        end
    end

    assign err_count_o = 16'(err_cnt);

endmodule

// File: doc/twpm_wb_router.md
Name: twpm_wb_router

Overview:
- Single-master Wishbone router between the NEORV32 external bus and four slave regions: DDR3 user port, LiteDRAM controller CSRs, TPM communication registers and TPM command/response RAM.
- Decodes the address and forwards one transaction at a time to the selected slave.
- Muxes back read data, ack and err to the master.
- Converts unmapped accesses and hung slaves into bus errors, so the CPU never stalls forever.

Parameters:
- RAM_BASE_ADDRESS, 32'h80000000, DDR3 window base (slave 0)
- RAM_ADDR_WIDTH, 27, DDR3 window size in address bits
- LITEDRAM_BASE_ADDRESS, 32'hF8000000, LiteDRAM CSR window base (slave 1)
- LITEDRAM_ADDR_WIDTH, 14, CSR window size in address bits
- TPM_REGS_BASE_ADDRESS, 32'hF0000000, TPM register window base (slave 2)
- TPM_REGS_ADDR_WIDTH, 11, register window size in address bits
- TPM_RAM_BASE_ADDRESS, 32'hF0000800, TPM buffer window base (slave 3)
- TPM_RAM_ADDR_WIDTH, 11, buffer window size in address bits
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for a slave response (≥2)
- DEFAULT_READ_VALUE, 32'hBADFABAC, read data returned on decode miss or timeout

Ports:
- clk_i  in  1  system clock (CPU/Wishbone clock)
- rst_i  in  1  reset; asynchronous, active-high
- wb_adr_i  in  32  master address
- wb_dat_i  in  32  master write data
- wb_dat_o  out  32  read data to master
- wb_we_i  in  1  master write enable
- wb_sel_i  in  4  master byte enables
- wb_stb_i  in  1  master strobe
- wb_cyc_i  in  1  master cycle valid
- wb_ack_o  out  1  transfer ack to master
- wb_err_o  out  1  transfer error to master
- s_adr_o  out  32  address broadcast to all slaves
- s_dat_o  out  32  write data broadcast
- s_sel_o  out  4  byte enables broadcast
- s_we_o  out  1  write enable, valid only with a slave strobe
- s_cyc_o  out  4  per-slave cycle
- s_stb_o  out  4  per-slave strobe; bit n = slave n
- s_dat_i  in  128  slave read data; slave n in bits [32n+31:32n]
- s_ack_i  in  4  per-slave ack
- s_err_i  in  4  per-slave err
- busy_o  out  1  transaction in flight (state BUSY)
- timeout_o  out  1  one-cycle pulse when a timeout fires
- err_count_o  out  16  saturating count of errors returned to the master

Behaviour:
- Decode: hit_n = (wb_adr_i[31:W_n] == BASE_n[31:W_n]). If several hit, priority is 0 > 1 > 2 > 3.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - If wb_cyc_i & wb_stb_i and some slave hits: latch the index in sel_q, clear the timeout counter, go to BUSY.
  - If wb_cyc_i & wb_stb_i and no slave hits: latch rdata_q = DEFAULT_READ_VALUE and err_q = 1, go to DONE.
- BUSY:
  - s_cyc_o[sel_q] = s_stb_o[sel_q] = 1; all other bits 0. s_we_o = wb_we_i.
  - s_adr_o, s_dat_o and s_sel_o pass through combinationally at all times.
  - Timeout counter increments each cycle.
  - On s_ack_i[sel_q] | s_err_i[sel_q]: latch rdata_q = s_dat_i slice, err_q = s_err_i[sel_q], go to DONE.
  - Ack and err together: err wins.
  - Slave response and counter == TIMEOUT_CYCLES-1 in the same cycle: the response wins.
  - Otherwise, at counter == TIMEOUT_CYCLES-1: rdata_q = DEFAULT_READ_VALUE, err_q = 1, timeout_o pulses, go to DONE.
  - Responses on non-selected slave lines are ignored.
- DONE:
  - wb_ack_o = ~err_q and wb_err_o = err_q for exactly one cycle; wb_dat_o = rdata_q.
  - err_count_o increments on err, saturating at 16'hFFFF.
  - Always returns to IDLE. The master must drop stb after ack; a still-high stb in IDLE starts a new transaction.
- Abort: wb_cyc_i falling in BUSY drops all slave strobes next cycle, returns to IDLE, and produces no ack/err and no count.
- Latency: decode miss gives err 1 cycle after stb. A slave acking in its first strobed cycle gives master ack 2 cycles after stb. In general, master ack = slave latency + 1 cycle.
- Outputs are registered except the s_* signals and busy_o.
- Reset (async assert, sync deassert by upstream):
  - state = IDLE; wb_ack_o = wb_err_o = 0; wb_dat_o = 0.
  - s_stb_o = s_cyc_o = 0; timeout_o = 0; err_count_o = 0.
  - Reset mid-BUSY drops the slave strobe immediately; no response is delivered.

Test Plan:
- Read 0x80000010, DDR3 stub acks after 3 cycles with 0x12345678 -> s_stb_o = 4'b0001 for 3 cycles; wb_ack_o one cycle later with wb_dat_o = 0x12345678; err_count_o = 0.
- Write 0xF0000040, data 0x1, sel 4'hF, TPM regs stub acks in its first cycle -> s_stb_o = 4'b0100, s_we_o = 1; wb_ack_o 2 cycles after stb.
- Read unmapped 0x00001000 -> no slave strobe; wb_err_o 1 cycle after stb; wb_dat_o = 0xBADFABAC; err_count_o = 1.
- TIMEOUT_CYCLES = 8, TPM RAM stub (0xF0000800) never responds -> s_stb_o[3] high for 8 cycles; timeout_o pulse; wb_err_o with 0xBADFABAC.
- Stub asserts ack and err together; a separate case asserts ack exactly on the timeout cycle -> the first gives err; the second gives ack with slave data and no timeout_o pulse.
- wb_cyc_i dropped in BUSY, then rst_i pulsed mid-BUSY in a second case -> slave strobes low, no ack/err, state IDLE; 0x10000 forced errors -> err_count_o saturates at 16'hFFFF.
